// File: rtl/nano_mmio_bus.sv
// Bus block between the nanoprocessor data port and RAM: decodes a window of
// memory-mapped output registers and records every processor write in a trace FIFO.
module nano_mmio_bus #(
    parameter int                DATA_W      = 8,
    parameter int                ADDR_W      = 8,
    parameter int                N_OUT       = 2,
    parameter logic [ADDR_W-1:0] OUT_BASE    = 8'hF0,
    parameter int                TRACE_DEPTH = 16
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [ADDR_W-1:0]                cpu_addr,
    input  logic                             cpu_write,
    input  logic [DATA_W-1:0]                cpu_data_write,
    output logic [DATA_W-1:0]                cpu_data_read,
    output logic [ADDR_W-1:0]                ram_addr,
    output logic                             ram_write,
    output logic [DATA_W-1:0]                ram_data_write,
    input  logic [DATA_W-1:0]                ram_data_read,
    output logic [N_OUT*DATA_W-1:0]          out,
    output logic [N_OUT-1:0]                 out_strobe,
    output logic                             trace_valid,
    output logic [ADDR_W-1:0]                trace_addr,
    output logic [DATA_W-1:0]                trace_data,
    input  logic                             trace_pop,
    output logic [$clog2(TRACE_DEPTH+1)-1:0] trace_count,
    output logic [7:0]                       trace_ovf
);

    localparam int                PTR_W   = $clog2(TRACE_DEPTH);
    localparam int                CNT_W   = $clog2(TRACE_DEPTH + 1);
    localparam int                ENTRY_W = ADDR_W + DATA_W;
    // Window bounds carry one extra bit so OUT_BASE+N_OUT cannot wrap.
    localparam logic [ADDR_W:0]   WIN_LO  = {1'b0, OUT_BASE};
    localparam logic [ADDR_W:0]   WIN_HI  = WIN_LO + (ADDR_W + 1)'(N_OUT);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TRACE_DEPTH);

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic                    hit;
    logic [ADDR_W-1:0]       off;
    logic [N_OUT-1:0]        wr_sel;
    logic [DATA_W-1:0]       out_reg [N_OUT];

    logic [ENTRY_W-1:0]      mem [TRACE_DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [PTR_W-1:0]        rd_ptr_nxt;
    logic [CNT_W-1:0]        cnt_after_pop;
    logic                    full;
    logic                    do_push;
    logic                    do_pop;
    logic                    drop;

    // Address decode and combinational RAM pass-through
    assign hit            = ({1'b0, cpu_addr} >= WIN_LO) && ({1'b0, cpu_addr} < WIN_HI);
    assign off            = cpu_addr - OUT_BASE;
    assign ram_addr       = cpu_addr;
    assign ram_data_write = cpu_data_write;
    assign ram_write      = cpu_write & ~hit;

    always_comb begin
        cpu_data_read = ram_data_read;
        wr_sel        = '0;
        for (int k = 0; k < N_OUT; k++) begin
            if (hit && (off == ADDR_W'(k))) begin
                cpu_data_read = out_reg[k];
                wr_sel[k]     = cpu_write;
            end
        end
    end

    // Output registers and strobes
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_strobe <= '0;
            for (int k = 0; k < N_OUT; k++) out_reg[k] <= '0;
        end else begin
            out_strobe <= wr_sel;
            for (int k = 0; k < N_OUT; k++) begin
                if (wr_sel[k]) out_reg[k] <= cpu_data_write;
            end
        end
    end

    for (genvar g = 0; g < N_OUT; g++) begin : g_out
        assign out[g*DATA_W +: DATA_W] = out_reg[g];
    end

    // Trace FIFO control
    assign trace_valid   = (trace_count != '0);
    assign full          = (trace_count == CNT_MAX);
    assign do_pop        = trace_pop & trace_valid;
    assign do_push       = cpu_write & (~full | do_pop);
    assign drop          = cpu_write & full & ~do_pop;
    assign rd_ptr_nxt    = rd_ptr + PTR_W'(1);
    assign cnt_after_pop = trace_count - CNT_W'(do_pop);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            trace_count <= '0;
            trace_ovf   <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr_nxt;
            trace_count <= cnt_after_pop + CNT_W'(do_push);
            if (drop) trace_ovf <= sat_inc8(trace_ovf);
        end
    end

    // Trace storage and head register; head holds its value once the FIFO drains
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= {cpu_addr, cpu_data_write};
        if (cnt_after_pop != '0) begin
            if (do_pop) {trace_addr, trace_data} <= mem[rd_ptr_nxt];
        end else if (do_push) begin
            {trace_addr, trace_data} <= {cpu_addr, cpu_data_write};
        end
    end

endmodule

// File: tb/tb_nano_mmio_bus.sv
// Directed bench for nano_mmio_bus with default parameters (N_OUT=2, OUT_BASE=F0, depth 16).
module tb_nano_mmio_bus;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  cpu_addr;
    logic        cpu_write;
    logic [7:0]  cpu_data_write;
    logic [7:0]  cpu_data_read;
    logic [7:0]  ram_addr;
    logic        ram_write;
    logic [7:0]  ram_data_write;
    logic [7:0]  ram_data_read;
    logic [15:0] out_bus;
    logic [1:0]  out_strobe;
    logic        trace_valid;
    logic [7:0]  trace_addr;
    logic [7:0]  trace_data;
    logic        trace_pop;
    logic [4:0]  trace_count;
    logic [7:0]  trace_ovf;

    int checks = 0;
    int errors = 0;

    logic [7:0] ram_mem [256];

    always #5 clk = ~clk;

    assign ram_data_read = ram_mem[ram_addr];
    always @(posedge clk) if (ram_write) ram_mem[ram_addr] <= ram_data_write;

    nano_mmio_bus dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_addr(cpu_addr), .cpu_write(cpu_write), .cpu_data_write(cpu_data_write),
        .cpu_data_read(cpu_data_read),
        .ram_addr(ram_addr), .ram_write(ram_write), .ram_data_write(ram_data_write),
        .ram_data_read(ram_data_read),
        .out(out_bus), .out_strobe(out_strobe),
        .trace_valid(trace_valid), .trace_addr(trace_addr), .trace_data(trace_data),
        .trace_pop(trace_pop), .trace_count(trace_count), .trace_ovf(trace_ovf)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_data_write = '0; trace_pop = 1'b0;
        step(); step();
        reset_n = 1'b1;
        step();
        checks++; if (out_bus !== 16'h0000) begin errors++; $display("FAIL reset_out: got %h expected 0000", out_bus); end
        checks++; if (out_strobe !== 2'b00) begin errors++; $display("FAIL reset_strobe: got %b expected 00", out_strobe); end
        checks++; if (trace_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", trace_valid); end
        checks++; if (trace_count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", trace_count); end
        checks++; if (trace_ovf !== 8'd0) begin errors++; $display("FAIL reset_ovf: got %0d expected 0", trace_ovf); end
    endtask

    task automatic test_mmio_write();
        cpu_addr = 8'hF1; cpu_data_write = 8'hA5; cpu_write = 1'b1;
        #1;
        checks++; if (ram_write !== 1'b0) begin errors++; $display("FAIL mmio_ram_write: got %b expected 0", ram_write); end
        step();
        cpu_write = 1'b0;
        #1;
        checks++; if (out_bus !== 16'hA500) begin errors++; $display("FAIL mmio_out: got %h expected a500", out_bus); end
        checks++; if (out_strobe !== 2'b10) begin errors++; $display("FAIL mmio_strobe: got %b expected 10", out_strobe); end
        checks++; if (cpu_data_read !== 8'hA5) begin errors++; $display("FAIL mmio_read: got %h expected a5", cpu_data_read); end
        checks++; if (trace_valid !== 1'b1 || trace_addr !== 8'hF1 || trace_data !== 8'hA5) begin
            errors++; $display("FAIL mmio_trace: got v=%b %h/%h expected v=1 f1/a5", trace_valid, trace_addr, trace_data); end
        step();
        checks++; if (out_strobe !== 2'b00) begin errors++; $display("FAIL mmio_strobe_clear: got %b expected 00", out_strobe); end
        trace_pop = 1'b1; step(); trace_pop = 1'b0;
        checks++; if (trace_valid !== 1'b0 || trace_count !== 5'd0) begin
            errors++; $display("FAIL mmio_pop: got v=%b cnt=%0d expected v=0 cnt=0", trace_valid, trace_count); end
        checks++; if (trace_addr !== 8'hF1 || trace_data !== 8'hA5) begin
            errors++; $display("FAIL trace_hold: got %h/%h expected f1/a5", trace_addr, trace_data); end
    endtask

    task automatic test_back_to_back();
        cpu_addr = 8'hF0; cpu_data_write = 8'h11; cpu_write = 1'b1;
        step();
        checks++; if (out_strobe !== 2'b01 || out_bus !== 16'hA511) begin
            errors++; $display("FAIL b2b_first: got %b %h expected 01 a511", out_strobe, out_bus); end
        cpu_data_write = 8'h22;
        step();
        cpu_write = 1'b0;
        checks++; if (out_strobe !== 2'b01 || out_bus !== 16'hA522) begin
            errors++; $display("FAIL b2b_second: got %b %h expected 01 a522", out_strobe, out_bus); end
        checks++; if (trace_count !== 5'd2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", trace_count); end
        trace_pop = 1'b1; step(); step(); step(); trace_pop = 1'b0;
        checks++; if (trace_count !== 5'd0) begin errors++; $display("FAIL b2b_drain: got %0d expected 0", trace_count); end
    endtask

    task automatic test_ram_path();
        cpu_addr = 8'h10; cpu_data_write = 8'h3C; cpu_write = 1'b1;
        #1;
        checks++; if (ram_write !== 1'b1) begin errors++; $display("FAIL ram_write: got %b expected 1", ram_write); end
        step();
        cpu_write = 1'b0;
        #1;
        checks++; if (out_bus !== 16'hA522) begin errors++; $display("FAIL ram_out_unchanged: got %h expected a522", out_bus); end
        checks++; if (cpu_data_read !== 8'h3C) begin errors++; $display("FAIL ram_read: got %h expected 3c", cpu_data_read); end
        checks++; if (trace_addr !== 8'h10 || trace_data !== 8'h3C || trace_count !== 5'd1) begin
            errors++; $display("FAIL ram_trace: got %h/%h cnt=%0d expected 10/3c cnt=1", trace_addr, trace_data, trace_count); end
        trace_pop = 1'b1; step(); trace_pop = 1'b0;
        cpu_write = 1'b1; cpu_addr = 8'hF2;
        #1;
        checks++; if (ram_write !== 1'b1) begin errors++; $display("FAIL window_above: got %b expected 1", ram_write); end
        cpu_addr = 8'hEF;
        #1;
        checks++; if (ram_write !== 1'b1) begin errors++; $display("FAIL window_below: got %b expected 1", ram_write); end
        cpu_write = 1'b0;
        #1;
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 17; i++) begin
            cpu_write = 1'b1; cpu_addr = 8'(i); cpu_data_write = 8'(8'h40 + i);
            step();
        end
        cpu_write = 1'b0;
        checks++; if (trace_count !== 5'd16) begin errors++; $display("FAIL ovf_count: got %0d expected 16", trace_count); end
        checks++; if (trace_ovf !== 8'd1) begin errors++; $display("FAIL ovf_counter: got %0d expected 1", trace_ovf); end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (trace_valid !== 1'b1 || trace_addr !== 8'(i) || trace_data !== 8'(8'h40 + i)) begin
                errors++; $display("FAIL drain_%0d: got v=%b %h/%h expected v=1 %h/%h", i, trace_valid, trace_addr, trace_data, 8'(i), 8'(8'h40 + i));
            end
            trace_pop = 1'b1; step(); trace_pop = 1'b0;
        end
        checks++; if (trace_valid !== 1'b0) begin errors++; $display("FAIL drain_empty: got %b expected 0", trace_valid); end
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < 16; i++) begin
            cpu_write = 1'b1; cpu_addr = 8'(8'h20 + i); cpu_data_write = 8'(8'h80 + i);
            step();
        end
        cpu_write = 1'b1; cpu_addr = 8'h30; cpu_data_write = 8'h99; trace_pop = 1'b1;
        step();
        cpu_write = 1'b0; trace_pop = 1'b0;
        checks++; if (trace_count !== 5'd16 || trace_ovf !== 8'd1) begin
            errors++; $display("FAIL full_pp: got cnt=%0d ovf=%0d expected cnt=16 ovf=1", trace_count, trace_ovf); end
        checks++; if (trace_addr !== 8'h21 || trace_data !== 8'h81) begin
            errors++; $display("FAIL full_pp_head: got %h/%h expected 21/81", trace_addr, trace_data); end
        trace_pop = 1'b1;
        for (int i = 0; i < 15; i++) step();
        trace_pop = 1'b0;
        checks++; if (trace_count !== 5'd1 || trace_addr !== 8'h30 || trace_data !== 8'h99) begin
            errors++; $display("FAIL full_pp_tail: got cnt=%0d %h/%h expected cnt=1 30/99", trace_count, trace_addr, trace_data); end
        trace_pop = 1'b1; step();
        cpu_write = 1'b1; cpu_addr = 8'h31; cpu_data_write = 8'h55;
        checks++; if (trace_count !== 5'd0) begin errors++; $display("FAIL empty_before_pp: got %0d expected 0", trace_count); end
        step();
        cpu_write = 1'b0; trace_pop = 1'b0;
        checks++; if (trace_count !== 5'd1 || trace_valid !== 1'b1 || trace_addr !== 8'h31 || trace_data !== 8'h55) begin
            errors++; $display("FAIL empty_pp: got cnt=%0d v=%b %h/%h expected cnt=1 v=1 31/55", trace_count, trace_valid, trace_addr, trace_data); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) begin
            cpu_write = 1'b1; cpu_addr = 8'(8'h50 + i); cpu_data_write = 8'(i);
            step();
        end
        cpu_write = 1'b0;
        checks++; if (trace_count !== 5'd5 || out_bus === 16'h0000) begin
            errors++; $display("FAIL pre_reset: got cnt=%0d out=%h expected cnt=5 out nonzero", trace_count, out_bus); end
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        checks++; if (out_bus !== 16'h0000 || out_strobe !== 2'b00) begin
            errors++; $display("FAIL mid_reset_out: got %h %b expected 0000 00", out_bus, out_strobe); end
        checks++; if (trace_valid !== 1'b0 || trace_count !== 5'd0 || trace_ovf !== 8'd0) begin
            errors++; $display("FAIL mid_reset_fifo: got v=%b cnt=%0d ovf=%0d expected 0 0 0", trace_valid, trace_count, trace_ovf); end
    endtask

    task automatic test_ovf_saturate();
        cpu_write = 1'b1;
        for (int i = 0; i < 316; i++) begin
            cpu_addr = 8'(i); cpu_data_write = 8'(~i);
            step();
        end
        cpu_write = 1'b0;
        checks++; if (trace_ovf !== 8'd255) begin errors++; $display("FAIL ovf_sat: got %0d expected 255", trace_ovf); end
        checks++; if (trace_count !== 5'd16 || trace_addr !== 8'h00 || trace_data !== 8'hFF) begin
            errors++; $display("FAIL ovf_sat_head: got cnt=%0d %h/%h expected cnt=16 00/ff", trace_count, trace_addr, trace_data); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram_mem[i] = 8'h00;
        test_reset();
        test_mmio_write();
        test_back_to_back();
        test_ram_path();
        test_overflow();
        test_full_push_pop();
        test_reset_mid();
        test_ovf_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
